// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PC_W               : program counter width
//   NOP_INSTR_DEFAULT  : addi x0,x0,0, driven when no instruction is valid
//   ST_IDLE/REQ/WAIT   : fetch FSM state encodings
//   fetch_entry_t      : {pc, instr} pair held by the skid buffer
//   fetch_dbg_t        : bundle of internal state for checkers to bind to
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [1:0] state;
    logic       kill;
    logic       buf_full;
    logic       misaligned;
  } fetch_dbg_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold buffer for a completed fetch that downstream could not take.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : drop the held entry (highest priority)
//   i_push       : capture i_entry
//   i_pop        : release the held entry
//   i_entry      : {pc, instr} to capture
//   o_full       : an entry is held
//   o_entry      : the held entry
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         r_full;
  fetch_entry_t r_entry;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full  <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full  <= 1'b1;
      r_entry <= i_entry;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction-memory request at a time and
// drives a registered {pc, instruction, pc+4, valid} into the IF/ID register.
// A stalled completion is parked in a one-entry skid buffer; a redirect kills
// in-flight work and restarts fetch at a new PC.
//
// Optional build macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned PC raises o_misaligned (sticky
//               until reset or the next aligned redirect) and fetch halts.
//   undefined : o_misaligned is 0 and redirect targets are forced word-aligned.
//
// Handshakes:
//   Request : o_imem_req is held with o_imem_addr until a cycle with
//             i_imem_ready=1; that cycle is the transfer. Only one request is
//             ever outstanding.
//   Response: i_imem_rvalid is a one-cycle pulse carrying i_imem_rdata, at least
//             one cycle after acceptance. It is consumed only in WAIT, or as the
//             stale response of a killed request.
//   Output  : o_valid pulses for exactly one cycle per delivered instruction;
//             when low, o_pc=0, o_instruction=NOP_INSTR, o_pc_plus_4=4.
//
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_stall             : downstream cannot accept
//   i_redirect          : restart at i_redirect_pc (wins over i_stall)
//   i_redirect_pc       : redirect target
//   o_imem_req/addr     : instruction memory request
//   i_imem_ready        : request accepted
//   i_imem_rvalid/rdata : instruction memory response
//   o_pc, o_instruction, o_pc_plus_4, o_valid : IF/ID outputs
//   o_misaligned        : misaligned redirect flag
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic [PC_W-1:0] o_pc,
  output logic [31:0]     o_instruction,
  output logic [PC_W-1:0] o_pc_plus_4,
  output logic            o_valid,
  output logic            o_misaligned
);

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_kill;
  logic            r_misaligned;

  logic [PC_W-1:0] r_out_pc;
  logic [31:0]     r_out_instr;
  logic [PC_W-1:0] r_out_pc4;
  logic            r_out_valid;

  logic            w_buf_full;
  fetch_entry_t    w_buf_entry;
  fetch_entry_t    w_new_entry;
  logic            w_req;
  logic            w_accept;
  logic            w_resp;
  logic            w_deliver;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_target;
  logic            w_target_bad;
  fetch_dbg_t      w_dbg;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_target     = i_redirect_pc;
  assign w_target_bad = |i_redirect_pc[1:0];
`else
  logic w_unused_lo;
  assign w_unused_lo  = ^i_redirect_pc[1:0];
  assign w_target     = {i_redirect_pc[PC_W-1:2], 2'b00};
  assign w_target_bad = 1'b0;
`endif

  // A request waits while a word is parked, while a killed response is still
  // due (so that response cannot be taken for the new one), or while halted
  // on a misaligned target.
  assign w_req     = (r_state == ST_REQ) && !w_buf_full && !r_kill && !r_misaligned;
  assign w_accept  = w_req && i_imem_ready;
  assign w_resp    = (r_state == ST_WAIT) && i_imem_rvalid && !r_kill;
  assign w_deliver = w_resp && !i_redirect && !i_stall;
  assign w_push    = w_resp && !i_redirect && i_stall;
  assign w_pop     = w_buf_full && !i_stall && !i_redirect;

  assign w_new_entry.pc    = r_pc;
  assign w_new_entry.instr = i_imem_rdata;

  fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_new_entry),
    .o_full  (w_buf_full),
    .o_entry (w_buf_entry)
  );

  // Fetch FSM, PC and kill tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (i_redirect) begin
      r_state      <= ST_REQ;
      r_pc         <= w_target;
      r_misaligned <= w_target_bad;
      // Kill is needed whenever a response is still owed: waiting without
      // rvalid, accepting this very cycle, or an older kill not yet drained.
      r_kill       <= ((r_state == ST_WAIT) && !i_imem_rvalid) || w_accept ||
                      (r_kill && !i_imem_rvalid);
    end else begin
      if (r_kill && i_imem_rvalid) begin
        r_kill <= 1'b0;
      end
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
          if (w_accept) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_resp) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // IF/ID output register: non-valid cycles carry the reset values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= NOP_INSTR;
      r_out_pc4   <= 32'd4;
    end else if (w_deliver) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_pc;
      r_out_instr <= i_imem_rdata;
      r_out_pc4   <= r_pc + 32'd4;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= w_buf_entry.pc;
      r_out_instr <= w_buf_entry.instr;
      r_out_pc4   <= w_buf_entry.pc + 32'd4;
    end else begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= NOP_INSTR;
      r_out_pc4   <= 32'd4;
    end
  end

  assign w_dbg.state      = r_state;
  assign w_dbg.kill       = r_kill;
  assign w_dbg.buf_full   = w_buf_full;
  assign w_dbg.misaligned = r_misaligned;

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_out_pc;
  assign o_instruction = r_out_instr;
  assign o_pc_plus_4   = r_out_pc4;
  assign o_valid       = r_out_valid;
  assign o_misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus_4;
  logic        o_valid;
  logic        o_misaligned;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // clock / reset block
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  fetch_stage dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_pc_plus_4   (o_pc_plus_4),
    .o_valid       (o_valid),
    .o_misaligned  (o_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // instruction memory model: accepts when req&ready, answers lat cycles later
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;

  always @(negedge i_clk) begin
    i_imem_rvalid = 1'b0;
    if (i_rst) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_word(mem_addr);
          mem_busy      = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (o_imem_req && i_imem_ready) begin
        mem_busy = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = o_imem_addr;
      end
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < max_cyc);
    checks++;
    assert (o_valid === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=no o_valid within %0d cycles expected=o_valid", tag, max_cyc);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr, input int max_cyc, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_imem_req && o_imem_addr == addr) && n < max_cyc);
    checks++;
    assert (o_imem_req === 1'b1 && o_imem_addr === addr) else begin
      failures++;
      $error("FAIL %s observed=req %b addr %h expected=req 1 addr %h", tag, o_imem_req, o_imem_addr, addr);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    @(negedge i_clk);
    i_redirect    = 1'b0;
  endtask

  // directed stimulus
  initial begin
    int t0;
    logic seen_bad;
    i_imem_ready  = 1'b1;
    i_redirect_pc = '0;
    i_imem_rdata  = '0;

    // reset values
    do_reset();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instruction, 32'h0000_0013);
    chk("rst_pc4", o_pc_plus_4, 32'h4);
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_mis", {31'd0, o_misaligned}, 32'd0);

    // streaming fetch: 0, 4, 8 at one instruction per two cycles
    wait_valid(10, "seq_v0");
    chk("seq_pc0", o_pc, 32'h0);
    chk("seq_ins0", o_instruction, 32'hFFFF_0000);
    chk("seq_pc4_0", o_pc_plus_4, 32'h4);
    t0 = cyc;
    wait_valid(10, "seq_v4");
    chk("seq_pc4", o_pc, 32'h4);
    chk("seq_ins4", o_instruction, 32'hFFFB_0004);
    chk("seq_gap", cyc - t0, 32'd2);
    wait_valid(10, "seq_v8");
    chk("seq_pc8", o_pc, 32'h8);
    chk("seq_pc4_8", o_pc_plus_4, 32'hC);

    // stall for 3 cycles while the word at 8 returns
    do_reset();
    wait_valid(10, "st_v0");
    wait_valid(10, "st_v4");
    chk("st_pc4", o_pc, 32'h4);
    @(negedge i_clk);
    i_stall = 1'b1;
    chk("st_v_a", {31'd0, o_valid}, 32'd0);
    @(negedge i_clk);
    chk("st_v_b", {31'd0, o_valid}, 32'd0);
    chk("st_req_b", {31'd0, o_imem_req}, 32'd0);
    chk("st_ins_b", o_instruction, 32'h0000_0013);
    @(negedge i_clk);
    chk("st_v_c", {31'd0, o_valid}, 32'd0);
    chk("st_req_c", {31'd0, o_imem_req}, 32'd0);
    @(negedge i_clk);
    i_stall = 1'b0;
    chk("st_v_d", {31'd0, o_valid}, 32'd0);
    chk("st_req_d", {31'd0, o_imem_req}, 32'd0);
    @(negedge i_clk);
    chk("st_rel_v", {31'd0, o_valid}, 32'd1);
    chk("st_rel_pc", o_pc, 32'h8);
    chk("st_rel_ins", o_instruction, 32'hFFF7_0008);
    chk("st_rel_pc4", o_pc_plus_4, 32'hC);
    wait_valid(10, "st_vC");
    chk("st_pcC", o_pc, 32'hC);

    // redirect while waiting for the word at 4: that word is dropped
    do_reset();
    mem_lat = 3;
    wait_req(32'h4, 20, "rw_req4");
    @(negedge i_clk);
    redirect_to(32'h100);
    mem_lat = 1;
    chk("rw_v", {31'd0, o_valid}, 32'd0);
    wait_valid(40, "rw_v100");
    chk("rw_pc", o_pc, 32'h100);
    chk("rw_ins", o_instruction, 32'hFEFF_0100);

    // redirect with stall high and the buffer holding the word at 0x104
    @(negedge i_clk);
    i_stall = 1'b1;
    @(negedge i_clk);
    chk("rs_req_parked", {31'd0, o_imem_req}, 32'd0);
    redirect_to(32'h40);
    chk("rs_v", {31'd0, o_valid}, 32'd0);
    chk("rs_req", {31'd0, o_imem_req}, 32'd1);
    chk("rs_addr", o_imem_addr, 32'h40);
    @(negedge i_clk);
    chk("rs_v2", {31'd0, o_valid}, 32'd0);
    i_stall = 1'b0;
    wait_valid(10, "rs_v40");
    chk("rs_pc", o_pc, 32'h40);
    chk("rs_ins", o_instruction, 32'hFFBF_0040);

    // wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    wait_valid(20, "wr_v");
    chk("wr_pc", o_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", o_pc_plus_4, 32'h0);
    chk("wr_ins", o_instruction, 32'h0003_FFFC);
    chk("wr_req", {31'd0, o_imem_req}, 32'd1);
    chk("wr_addr", o_imem_addr, 32'h0);

    // misaligned redirect
    redirect_to(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("ma_flag", {31'd0, o_misaligned}, 32'd1);
    chk("ma_req", {31'd0, o_imem_req}, 32'd0);
    seen_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (o_valid || o_imem_req || !o_misaligned) seen_bad = 1'b1;
    end
    chk("ma_hold", {31'd0, seen_bad}, 32'd0);
    redirect_to(32'h200);
    chk("ma_clear", {31'd0, o_misaligned}, 32'd0);
    wait_valid(20, "ma_v200");
    chk("ma_pc", o_pc, 32'h200);
`else
    seen_bad = o_misaligned;
    chk("al_flag", {31'd0, seen_bad}, 32'd0);
    wait_valid(20, "al_v");
    chk("al_pc", o_pc, 32'h100);
    chk("al_flag2", {31'd0, o_misaligned}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
